// File: rtl/pipelined_shifter.sv
// Two-stage pipelined shift/rotate unit with valid/ready handshake on both sides.
// Left ops run as right ops on bit-reversed data; the amount is split across the two stages.
module pipelined_shifter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  input  logic [2:0]               in_op,
  input  logic [$clog2(WIDTH)-1:0] in_amt,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_zero,
  output logic                     out_err
);

  localparam int unsigned SW = $clog2(WIDTH);
  localparam int unsigned LO = SW / 2;
  localparam int unsigned HI = SW - LO;

  typedef enum logic [2:0] {
    OP_ROL = 3'b000,
    OP_SLL = 3'b001,
    OP_ROR = 3'b010,
    OP_SRL = 3'b011,
    OP_SRA = 3'b100
  } op_e;

  function automatic logic [WIDTH-1:0] rev(input logic [WIDTH-1:0] x);
    logic [WIDTH-1:0] r;
    for (int unsigned i = 0; i < WIDTH; i++) r[i] = x[WIDTH-1-i];
    return r;
  endfunction

  // sh never exceeds WIDTH/2, so the wrap/fill shift below stays in range
  function automatic logic [WIDTH-1:0] shr(input logic [WIDTH-1:0] x, input int unsigned sh,
                                           input logic rot, input logic fill);
    logic [WIDTH-1:0] wrap;
    wrap = rot ? x : {WIDTH{fill}};
    return (x >> sh) | (wrap << (WIDTH - sh));
  endfunction

  function automatic logic op_legal(input logic [2:0] op);
    return op <= OP_SRA;
  endfunction

  function automatic logic op_left(input logic [2:0] op);
    return (op == OP_ROL) || (op == OP_SLL);
  endfunction

  function automatic logic op_rot(input logic [2:0] op);
    return (op == OP_ROL) || (op == OP_ROR);
  endfunction

  logic             s1_valid_q, s2_valid_q;
  logic             s1_adv, s2_adv;
  logic [WIDTH-1:0] s1_data_q, s1_data_d;
  logic [HI-1:0]    s1_amt_q, s1_amt_d;
  logic [2:0]       s1_op_q;
  logic             s1_sign_q;
  logic [WIDTH-1:0] s2_data_q, s2_data_d;
  logic             s2_zero_q, s2_zero_d;
  logic             s2_err_q, s2_err_d;

  assign s2_adv   = ~s2_valid_q | out_ready;
  assign s1_adv   = ~s1_valid_q | s2_adv;
  assign in_ready = s1_adv;

  always_comb begin
    s1_data_d = op_left(in_op) ? rev(in_data) : in_data;
    s1_amt_d  = '0;
    if (op_legal(in_op)) begin
      for (int unsigned i = 0; i < LO; i++) begin
        if (in_amt[i])
          s1_data_d = shr(s1_data_d, 32'd1 << i, op_rot(in_op),
                          (in_op == OP_SRA) & in_data[WIDTH-1]);
      end
      s1_amt_d = in_amt[SW-1:LO];
    end
  end

  always_comb begin
    s2_data_d = s1_data_q;
    for (int unsigned j = 0; j < HI; j++) begin
      if (s1_amt_q[j])
        s2_data_d = shr(s2_data_d, 32'd1 << (LO + j), op_rot(s1_op_q),
                        (s1_op_q == OP_SRA) & s1_sign_q);
    end
    if (op_left(s1_op_q)) s2_data_d = rev(s2_data_d);
    s2_zero_d = (s2_data_d == '0);
    s2_err_d  = ~op_legal(s1_op_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_amt_q   <= '0;
      s1_op_q    <= '0;
      s1_sign_q  <= 1'b0;
    end else if (s1_adv) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_data_q <= s1_data_d;
        s1_amt_q  <= s1_amt_d;
        s1_op_q   <= in_op;
        s1_sign_q <= in_data[WIDTH-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_zero_q  <= 1'b0;
      s2_err_q   <= 1'b0;
    end else if (s2_adv) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_data_q <= s2_data_d;
        s2_zero_q <= s2_zero_d;
        s2_err_q  <= s2_err_d;
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign out_data  = s2_data_q;
  assign out_zero  = s2_zero_q;
  assign out_err   = s2_err_q;

endmodule

// File: tb/tb_pipelined_shifter.sv
// Bench for pipelined_shifter: directed WIDTH=16 sequences, then a concurrent randomised
// sweep on WIDTH=16/32/8 instances against a bit-level reference model.
module tb_pipelined_shifter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        v_in   [3];
  logic [2:0]  v_op   [3];
  logic [5:0]  v_amt  [3];
  logic [63:0] v_data [3];
  logic        v_ordy [3];
  logic        i_rdy  [3];
  logic        o_valid[3];
  logic        o_zero [3];
  logic        o_err  [3];
  logic [15:0] od0;
  logic [31:0] od1;
  logic [7:0]  od2;

  int unsigned total = 0;
  int unsigned bad   = 0;

  pipelined_shifter #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(v_in[0]), .in_ready(i_rdy[0]), .in_data(v_data[0][15:0]),
    .in_op(v_op[0]), .in_amt(v_amt[0][3:0]), .out_valid(o_valid[0]), .out_ready(v_ordy[0]),
    .out_data(od0), .out_zero(o_zero[0]), .out_err(o_err[0]));

  pipelined_shifter #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .in_valid(v_in[1]), .in_ready(i_rdy[1]), .in_data(v_data[1][31:0]),
    .in_op(v_op[1]), .in_amt(v_amt[1][4:0]), .out_valid(o_valid[1]), .out_ready(v_ordy[1]),
    .out_data(od1), .out_zero(o_zero[1]), .out_err(o_err[1]));

  pipelined_shifter #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(v_in[2]), .in_ready(i_rdy[2]), .in_data(v_data[2][7:0]),
    .in_op(v_op[2]), .in_amt(v_amt[2][2:0]), .out_valid(o_valid[2]), .out_ready(v_ordy[2]),
    .out_data(od2), .out_zero(o_zero[2]), .out_err(o_err[2]));

  function automatic logic [63:0] odata(input int k);
    case (k)
      0:       return {48'b0, od0};
      1:       return {32'b0, od1};
      default: return {56'b0, od2};
    endcase
  endfunction

  // Result bit j is picked straight from the operand by the op's definition; bit 64 = illegal op.
  function automatic logic [64:0] ref_model(input int unsigned w, input logic [2:0] op,
                                            input int unsigned amt, input logic [63:0] d);
    logic [63:0] r;
    r = '0;
    if (op > 3'd4) return {1'b1, d};
    for (int unsigned j = 0; j < w; j++) begin
      case (op)
        3'd0:    r[j] = d[(j + w - amt) % w];
        3'd1:    r[j] = (j >= amt) ? d[j - amt] : 1'b0;
        3'd2:    r[j] = d[(j + amt) % w];
        3'd3:    r[j] = (j + amt < w) ? d[j + amt] : 1'b0;
        default: r[j] = (j + amt < w) ? d[j + amt] : d[w - 1];
      endcase
    end
    return {1'b0, r};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic v, input logic [2:0] op, input logic [5:0] amt,
                     input logic [63:0] d);
    v_in[0]   = v;
    v_op[0]   = op;
    v_amt[0]  = amt;
    v_data[0] = d;
  endtask

  logic [2:0]  b_op  [8];
  logic [5:0]  b_amt [8];
  logic [63:0] b_data[8];
  logic [63:0] b_exp [8];
  logic        b_zero[8];
  logic        b_err [8];

  task automatic run_burst(input int n, input string name);
    for (int i = 0; i < n + 2; i++) begin
      if (i < n) drv(1'b1, b_op[i], b_amt[i], b_data[i]);
      else       drv(1'b0, 3'd0, 6'd0, 64'd0);
      @(posedge clk); #1;
      if (i == 0) chk($sformatf("%s lat", name), o_valid[0], 1'b0);
      else if (i <= n) begin
        chk($sformatf("%s[%0d] valid", name, i - 1), o_valid[0], 1'b1);
        chk($sformatf("%s[%0d] data",  name, i - 1), odata(0), b_exp[i - 1]);
        chk($sformatf("%s[%0d] zero",  name, i - 1), o_zero[0], b_zero[i - 1]);
        chk($sformatf("%s[%0d] err",   name, i - 1), o_err[0], b_err[i - 1]);
      end else chk($sformatf("%s end", name), o_valid[0], 1'b0);
    end
  endtask

  int unsigned wid [3];
  int unsigned idx [3];
  int unsigned nreq[3];
  int unsigned wr  [3];
  int unsigned rd  [3];
  logic [64:0] exp_mem [3][512];
  logic        busy;
  logic [64:0] e;

  initial begin
    for (int k = 0; k < 3; k++) begin
      v_in[k] = 1'b0; v_op[k] = '0; v_amt[k] = '0; v_data[k] = '0; v_ordy[k] = 1'b1;
    end

    // reset state, checked while reset is held and right after release
    #2;
    chk("rst valid", o_valid[0], 1'b0);
    chk("rst data",  odata(0), 64'h0);
    chk("rst zero",  o_zero[0], 1'b0);
    chk("rst err",   o_err[0], 1'b0);
    chk("rst ready", i_rdy[0], 1'b1);
    #10 rst = 1'b0;
    @(posedge clk); #1;
    chk("post-rst ready", i_rdy[0], 1'b1);

    // back-to-back ops with out_ready high
    b_op[0] = 3'd0; b_amt[0] = 6'd1;  b_data[0] = 64'h8001; b_exp[0] = 64'h0003;
    b_op[1] = 3'd1; b_amt[1] = 6'd4;  b_data[1] = 64'h8001; b_exp[1] = 64'h0010;
    b_op[2] = 3'd2; b_amt[2] = 6'd1;  b_data[2] = 64'h8001; b_exp[2] = 64'hC000;
    b_op[3] = 3'd3; b_amt[3] = 6'd15; b_data[3] = 64'h8001; b_exp[3] = 64'h0001;
    b_op[4] = 3'd4; b_amt[4] = 6'd15; b_data[4] = 64'h8000; b_exp[4] = 64'hFFFF;
    for (int i = 0; i < 5; i++) begin b_zero[i] = 1'b0; b_err[i] = 1'b0; end
    run_burst(5, "b2b");

    // zero flag and illegal op
    b_op[0] = 3'd1; b_amt[0] = 6'd0; b_data[0] = 64'h0001; b_exp[0] = 64'h0001;
    b_zero[0] = 1'b0; b_err[0] = 1'b0;
    b_op[1] = 3'd3; b_amt[1] = 6'd1; b_data[1] = 64'h0001; b_exp[1] = 64'h0000;
    b_zero[1] = 1'b1; b_err[1] = 1'b0;
    b_op[2] = 3'd6; b_amt[2] = 6'd5; b_data[2] = 64'h1234; b_exp[2] = 64'h1234;
    b_zero[2] = 1'b0; b_err[2] = 1'b1;
    run_burst(3, "zerr");

    // backpressure: capacity two, stable output, ordered drain
    v_ordy[0] = 1'b0;
    drv(1'b1, 3'd3, 6'd4, 64'h00F0);
    @(posedge clk); #1;
    chk("bp ready1", i_rdy[0], 1'b1);
    drv(1'b1, 3'd0, 6'd8, 64'h1234);
    @(posedge clk); #1;
    chk("bp full", i_rdy[0], 1'b0);
    chk("bp valid", o_valid[0], 1'b1);
    chk("bp data0", odata(0), 64'h000F);
    drv(1'b1, 3'd4, 6'd2, 64'h8010);
    @(posedge clk); #1;
    chk("bp hold1 ready", i_rdy[0], 1'b0);
    chk("bp hold1 data", odata(0), 64'h000F);
    @(posedge clk); #1;
    chk("bp hold2 ready", i_rdy[0], 1'b0);
    chk("bp hold2 data", odata(0), 64'h000F);
    v_ordy[0] = 1'b1; #1;
    chk("bp ready comb", i_rdy[0], 1'b1);
    @(posedge clk); #1;
    drv(1'b0, 3'd0, 6'd0, 64'd0);
    chk("bp drain1 valid", o_valid[0], 1'b1);
    chk("bp drain1 data", odata(0), 64'h3412);
    @(posedge clk); #1;
    chk("bp drain2 valid", o_valid[0], 1'b1);
    chk("bp drain2 data", odata(0), 64'hE004);
    @(posedge clk); #1;
    chk("bp empty", o_valid[0], 1'b0);

    // reset with two requests in flight
    v_ordy[0] = 1'b0;
    drv(1'b1, 3'd6, 6'd5, 64'h1234);
    @(posedge clk); #1;
    drv(1'b1, 3'd2, 6'd3, 64'h00FF);
    @(posedge clk); #1;
    drv(1'b0, 3'd0, 6'd0, 64'd0);
    chk("mid pre err", o_err[0], 1'b1);
    #2 rst = 1'b1; #1;
    chk("mid rst valid", o_valid[0], 1'b0);
    chk("mid rst data", odata(0), 64'h0);
    chk("mid rst err", o_err[0], 1'b0);
    chk("mid rst zero", o_zero[0], 1'b0);
    chk("mid rst ready", i_rdy[0], 1'b1);
    @(posedge clk); #2 rst = 1'b0;
    v_ordy[0] = 1'b1;
    chk("mid rel ready", i_rdy[0], 1'b1);
    drv(1'b1, 3'd2, 6'd4, 64'h0001);
    @(posedge clk); #1;
    drv(1'b0, 3'd0, 6'd0, 64'd0);
    chk("mid new lat", o_valid[0], 1'b0);
    @(posedge clk); #1;
    chk("mid new valid", o_valid[0], 1'b1);
    chk("mid new data", odata(0), 64'h1000);
    @(posedge clk); #1;
    chk("mid no extra", o_valid[0], 1'b0);

    // randomised sweep on all three widths concurrently
    wid[0] = 16; wid[1] = 32; wid[2] = 8;
    for (int k = 0; k < 3; k++) begin
      nreq[k] = 5 * wid[k] + 3; idx[k] = 0; wr[k] = 0; rd[k] = 0;
    end
    for (int cyc = 0; cyc < 5000; cyc++) begin
      busy = 1'b0;
      for (int k = 0; k < 3; k++) if (idx[k] < nreq[k] || rd[k] != wr[k]) busy = 1'b1;
      if (!busy) break;
      for (int k = 0; k < 3; k++) begin
        v_ordy[k] = ($urandom_range(0, 3) != 0);
        if (idx[k] < nreq[k]) begin
          v_in[k] = ($urandom_range(0, 4) != 0);
          if (idx[k] < 5 * wid[k]) begin
            v_op[k]  = 3'(idx[k] / wid[k]);
            v_amt[k] = 6'(idx[k] % wid[k]);
          end else begin
            v_op[k]  = 3'(5 + idx[k] - 5 * wid[k]);
            v_amt[k] = 6'($urandom_range(0, wid[k] - 1));
          end
          v_data[k] = {$urandom, $urandom} & ((64'd1 << wid[k]) - 64'd1);
        end else v_in[k] = 1'b0;
      end
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        if (o_valid[k] && v_ordy[k]) begin
          if (rd[k] == wr[k]) chk($sformatf("sw%0d spurious", wid[k]), o_valid[k], 1'b0);
          else begin
            e = exp_mem[k][rd[k]];
            chk($sformatf("sw%0d[%0d] data", wid[k], rd[k]), odata(k), e[63:0]);
            chk($sformatf("sw%0d[%0d] err",  wid[k], rd[k]), o_err[k], e[64]);
            chk($sformatf("sw%0d[%0d] zero", wid[k], rd[k]), o_zero[k], e[63:0] == 64'd0);
            rd[k]++;
          end
        end
        if (v_in[k] && i_rdy[k]) begin
          exp_mem[k][wr[k]] = ref_model(wid[k], v_op[k], 32'(v_amt[k]), v_data[k]);
          wr[k]++;
          idx[k]++;
        end
      end
      @(posedge clk); #1;
    end
    for (int k = 0; k < 3; k++)
      chk($sformatf("sw%0d drained", wid[k]), 64'(rd[k]), 64'(nreq[k]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
